// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the program counter, drives the word
// address of a synchronous one-cycle-latency instruction memory, buffers the
// returned words in a 2-entry FIFO and hands them to decode over valid/ready.
// A redirect from execute flushes the buffer, discards the in-flight return
// and restarts fetch at the new target. A misaligned target halts fetch.
//
// Ports:
//   ifetch_clk, ifetch_rst_n   clock, async active-low reset
//   ifetch_mem_addr            word address to instruction memory (pc word index)
//   ifetch_mem_data            memory read data, one cycle after the address
//   ifetch_instr_valid/ready   decode handshake
//   ifetch_instr, _pc          FIFO head instruction and its byte PC
//   ifetch_redirect_valid/_pc  one-cycle redirect request and target
//   ifetch_pc                  byte PC of the next word to issue
//   ifetch_misaligned          sticky flag: last redirect target was misaligned
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned MEM_ADDR_WIDTH = 5
) (
  input  logic                      ifetch_clk,
  input  logic                      ifetch_rst_n,
  output logic [MEM_ADDR_WIDTH-1:0] ifetch_mem_addr,
  input  logic [31:0]               ifetch_mem_data,
  output logic                      ifetch_instr_valid,
  input  logic                      ifetch_instr_ready,
  output logic [31:0]               ifetch_instr,
  output logic [31:0]               ifetch_instr_pc,
  input  logic                      ifetch_redirect_valid,
  input  logic [31:0]               ifetch_redirect_pc,
  output logic [31:0]               ifetch_pc,
  output logic                      ifetch_misaligned
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned OCC_W   = 3;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [31:0]      pc;
  logic [31:0]      tag;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic             misaligned;
  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];

  logic             redirect_bad_c;
  logic             pop_c;
  logic             push_c;
  logic             issue_c;
  logic [OCC_W-1:0] occ_c;

  // Handshake and issue decisions for this cycle.
  always_comb begin
    redirect_bad_c = ifetch_redirect_valid & (ifetch_redirect_pc[1:0] != 2'b00);
    pop_c          = ifetch_instr_valid & ifetch_instr_ready;
    push_c         = inflight & ~ifetch_redirect_valid;
    // Occupancy after this edge's pop, counting the word still in flight;
    // pop implies count>=1 so this never underflows.
    occ_c          = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop_c);
    issue_c        = (state == ST_RUN) & ~ifetch_redirect_valid & (occ_c < OCC_W'(DEPTH));
  end

  // Next-state logic: redirect alone moves between RUN and HALT.
  always_comb begin
    state_next = state;
    if (ifetch_redirect_valid) begin
      state_next = redirect_bad_c ? ST_HALT : ST_RUN;
    end
  end

  // State register.
  always_ff @(posedge ifetch_clk or negedge ifetch_rst_n) begin
    if (!ifetch_rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // PC, in-flight tracking and FIFO storage.
  always_ff @(posedge ifetch_clk or negedge ifetch_rst_n) begin
    if (!ifetch_rst_n) begin
      pc         <= RESET_PC;
      tag        <= '0;
      inflight   <= 1'b0;
      count      <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      misaligned <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (ifetch_redirect_valid) begin
      // Redirect wins: drop buffered and in-flight words, restart at target.
      pc         <= ifetch_redirect_pc;
      inflight   <= 1'b0;
      count      <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      misaligned <= redirect_bad_c;
    end else begin
      inflight <= issue_c;
      if (issue_c) begin
        tag <= pc;
        pc  <= pc + 32'd4;
      end
      if (push_c) begin
        fifo_instr[wr_ptr] <= ifetch_mem_data;
        fifo_pc[wr_ptr]    <= tag;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop_c) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Valid is masked during a redirect so nothing transfers in that cycle.
  assign ifetch_instr_valid = (count != '0) & (state == ST_RUN) & ~ifetch_redirect_valid;
  assign ifetch_instr       = fifo_instr[rd_ptr];
  assign ifetch_instr_pc    = fifo_pc[rd_ptr];
  assign ifetch_mem_addr    = pc[MEM_ADDR_WIDTH+1:2];
  assign ifetch_pc          = pc;
  assign ifetch_misaligned  = misaligned;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl with a behavioural memory and a
// stream-level reference model (expected next PC per delivered instruction).
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  instr_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_ADDR_WIDTH(5)) dut (
    .ifetch_clk            (clk),
    .ifetch_rst_n          (rst_n),
    .ifetch_mem_addr       (mem_addr),
    .ifetch_mem_data       (mem_data),
    .ifetch_instr_valid    (instr_valid),
    .ifetch_instr_ready    (instr_ready),
    .ifetch_instr          (instr),
    .ifetch_instr_pc       (instr_pc),
    .ifetch_redirect_valid (redirect_valid),
    .ifetch_redirect_pc    (redirect_pc),
    .ifetch_pc             (pc),
    .ifetch_misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word k holds A000_0000+k, read data registered.
  initial mem_data = 32'h0;
  always @(posedge clk) mem_data <= 32'hA000_0000 + 32'(mem_addr);

  // Expected memory word at a byte PC, aliased to 32 words.
  function automatic logic [31:0] instr_of(input logic [31:0] p);
    return 32'hA000_0000 + 32'(p[6:2]);
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin failures++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL reset_misaligned: got %b expected 0", misaligned); end
    checks++; if (mem_addr !== 5'd0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", pc); end
    // Stream from reset with ready high: first valid in cycle 2, no gaps.
    instr_ready = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== (i >= 2)) begin failures++; $display("FAIL stream_valid c%0d: got %b expected %b", i, instr_valid, (i >= 2)); end
      if (i >= 2) begin
        checks++;
        if (instr_pc !== 32'(4 * (i - 2)) || instr !== instr_of(32'(4 * (i - 2)))) begin
          failures++; $display("FAIL stream_data c%0d: got (%h,%h) expected (%h,%h)", i, instr, instr_pc, instr_of(32'(4 * (i - 2))), 32'(4 * (i - 2)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int first;
    instr_ready = 1'b0;
    apply_reset();
    first = -1;
    for (int i = 0; i < 10 && first < 0; i++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) first = i; else next_cycle();
    end
    checks++; if (first != 2) begin failures++; $display("FAIL bp_first_valid: got cycle %0d expected 2", first); end
    // Five stalled cycles: head and address frozen.
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 || instr_pc !== 32'h0) begin
        failures++; $display("FAIL bp_head k%0d: got v=%b (%h,%h) expected v=1 (a0000000,0)", k, instr_valid, instr, instr_pc);
      end
      checks++; if (mem_addr !== 5'd2) begin failures++; $display("FAIL bp_mem_addr k%0d: got %0d expected 2", k, mem_addr); end
      checks++; if (dut.count > 2'd2) begin failures++; $display("FAIL bp_count k%0d: got %0d expected <=2", k, dut.count); end
      next_cycle();
    end
    instr_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * j) || instr !== instr_of(32'(4 * j))) begin
        failures++; $display("FAIL bp_drain j%0d: got v=%b (%h,%h) expected v=1 (%h,%h)", j, instr_valid, instr, instr_pc, instr_of(32'(4 * j)), 32'(4 * j));
      end
      next_cycle();
    end
  endtask

  // Issues a redirect now and checks the three-cycle restart sequence.
  task automatic redirect_and_expect(input logic [31:0] target, input int n_words, input string name);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL %s_redir_cycle_valid: got %b expected 0", name, instr_valid); end
    next_cycle();
    redirect_valid = 1'b0;
    for (int c = 1; c < 3 + n_words; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (mem_addr !== target[6:2]) begin failures++; $display("FAIL %s_mem_addr: got %h expected %h", name, mem_addr, target[6:2]); end
      end
      if (c < 3) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL %s_stale c%0d: got v=%b pc=%h expected v=0", name, c, instr_valid, instr_pc); end
      end else begin
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== target + 32'(4 * (c - 3)) || instr !== instr_of(target + 32'(4 * (c - 3)))) begin
          failures++; $display("FAIL %s_word c%0d: got v=%b (%h,%h) expected v=1 (%h,%h)", name, c, instr_valid, instr, instr_pc, instr_of(target + 32'(4 * (c - 3))), target + 32'(4 * (c - 3)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1;
    apply_reset();
    repeat (5) next_cycle();
    redirect_and_expect(32'h0000_0038, 3, "redir");
  endtask

  task automatic test_misaligned();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_003A;
    next_cycle();
    redirect_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (misaligned !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 5'd14 || pc !== 32'h0000_003A) begin
        failures++; $display("FAIL halt c%0d: got mis=%b v=%b addr=%0d pc=%h expected mis=1 v=0 addr=14 pc=0000003a", c, misaligned, instr_valid, mem_addr, pc);
      end
      next_cycle();
    end
    redirect_and_expect(32'h0000_0010, 2, "unhalt");
    @(negedge clk);
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL unhalt_misaligned: got %b expected 0", misaligned); end
    next_cycle();
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    redirect_and_expect(32'h0000_0078, 3, "wrap");
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b0;
    apply_reset();
    repeat (6) next_cycle();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || dut.count !== 2'd2) begin failures++; $display("FAIL areset_pre: got v=%b count=%0d expected v=1 count=2", instr_valid, dut.count); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin failures++; $display("FAIL areset_drop: got v=%b instr=%h expected v=0 instr=0", instr_valid, instr); end
    next_cycle();
    rst_n = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== (i >= 2) || (i >= 2 && instr_pc !== 32'(4 * (i - 2)))) begin
        failures++; $display("FAIL areset_restart c%0d: got v=%b pc=%h expected v=%b pc=%h", i, instr_valid, instr_pc, (i >= 2), 32'(4 * (i - 2)));
      end
      next_cycle();
    end
  endtask

  // Random ready and aligned redirects against a stream-level model.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        redir;
    int          since;
    exp_pc = 32'h0;
    since  = 0;
    for (int i = 0; i < 500; i++) begin
      redir = (i == 0) || ($urandom_range(0, 15) == 0);
      tgt   = $urandom;
      tgt[1:0] = 2'b00;
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = redir;
      redirect_pc    = tgt;
      @(negedge clk);
      if (redir) begin
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_redir_valid i%0d: got %b expected 0", i, instr_valid); end
        exp_pc = tgt;
        since  = 0;
      end else begin
        since++;
        if (since < 3) begin
          checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rnd_early i%0d: got v=%b expected 0", i, instr_valid); end
        end else if (since == 3) begin
          checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL rnd_latency i%0d: got v=%b expected 1", i, instr_valid); end
        end
        if (instr_valid === 1'b1 && instr_ready) begin
          checks++;
          if (instr_pc !== exp_pc || instr !== instr_of(exp_pc)) begin
            failures++; $display("FAIL rnd_xfer i%0d: got (%h,%h) expected (%h,%h)", i, instr, instr_pc, instr_of(exp_pc), exp_pc);
          end
          exp_pc = exp_pc + 32'd4;
        end
      end
      checks++; if (dut.count > 2'd2) begin failures++; $display("FAIL rnd_count i%0d: got %0d expected <=2", i, dut.count); end
      next_cycle();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
